// File: rtl/conv_row_sender.sv
// Ping-pong row buffer feeding the pooling layer.
// One buffer fills while the other is held for a single-cycle send pulse.
module conv_row_sender #(
  parameter int DATA_WIDTH   = 32,
  parameter int ROW_SIZE     = 6,
  parameter int NUM_ROWS     = 6,
  parameter int NUM_FEATURES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           in_ready,
  output logic                           valid,
  output logic [1:0]                     feature_idx,
  output logic [2:0]                     feature_row,
  output logic [ROW_SIZE*DATA_WIDTH-1:0] data_out,
  output logic                           frame_done
);

  localparam int CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RW = ROW_SIZE * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic            fill_ptr_q, fill_ptr_d;
  logic            send_ptr_q, send_ptr_d;
  logic [1:0]      full_q, full_d;
  logic [2:0]      row_q, row_d;
  logic [1:0]      feat_q, feat_d;
  logic [2:0]      frow_q, frow_d;
  logic [1:0]      fidx_q, fidx_d;
  logic [RW-1:0]   dout_q, dout_d;
  logic [RW-1:0]   send_row;
  logic            accept;
  logic            last_slot;
  logic            load;
  logic            rel;

  logic [DATA_WIDTH-1:0] buf_q [2][ROW_SIZE];

  assign in_ready  = ~rst & ~full_q[fill_ptr_q];
  assign accept    = in_valid & in_ready & ~clear;
  assign last_slot = (wr_cnt_q == CW'(ROW_SIZE - 1));

  assign valid       = (state_q == SEND) & ~clear;
  assign frame_done  = valid
                     & (fidx_q == 2'(NUM_FEATURES - 1))
                     & (frow_q == 3'(NUM_ROWS - 1));
  assign feature_idx = fidx_q;
  assign feature_row = frow_q;
  assign data_out    = dout_q;

  // Element 0 lands in the most significant slot.
  always_comb begin
    send_row = '0;
    for (int k = 0; k < ROW_SIZE; k++) begin
      send_row[RW-1-k*DATA_WIDTH -: DATA_WIDTH] = buf_q[send_ptr_q][k];
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    load    = 1'b0;
    rel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (full_q[send_ptr_q]) begin
          state_d = SEND;
          load    = 1'b1;
        end
      end
      SEND: begin
        rel     = 1'b1;
        gap_d   = '0;
        state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      gap_d   = '0;
      load    = 1'b0;
      rel     = 1'b0;
    end
  end

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    fill_ptr_d = fill_ptr_q;
    send_ptr_d = send_ptr_q;
    full_d     = full_q;
    row_d      = row_q;
    feat_d     = feat_q;
    frow_d     = frow_q;
    fidx_d     = fidx_q;
    dout_d     = dout_q;
    // Release and fill always target different buffers.
    if (rel) begin
      full_d[send_ptr_q] = 1'b0;
      send_ptr_d         = ~send_ptr_q;
    end
    if (accept) begin
      if (last_slot) begin
        full_d[fill_ptr_q] = 1'b1;
        wr_cnt_d           = '0;
        fill_ptr_d         = ~fill_ptr_q;
      end else begin
        wr_cnt_d = wr_cnt_q + CW'(1);
      end
    end
    if (load) begin
      dout_d = send_row;
      frow_d = row_q;
      fidx_d = feat_q;
      if (row_q == 3'(NUM_ROWS - 1)) begin
        row_d  = '0;
        feat_d = (feat_q == 2'(NUM_FEATURES - 1)) ? 2'd0 : feat_q + 2'd1;
      end else begin
        row_d = row_q + 3'd1;
      end
    end
    if (clear) begin
      wr_cnt_d   = '0;
      fill_ptr_d = 1'b0;
      send_ptr_d = 1'b0;
      full_d     = '0;
      row_d      = '0;
      feat_d     = '0;
      frow_d     = '0;
      fidx_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      wr_cnt_q   <= '0;
      fill_ptr_q <= 1'b0;
      send_ptr_q <= 1'b0;
      full_q     <= '0;
      row_q      <= '0;
      feat_q     <= '0;
      frow_q     <= '0;
      fidx_q     <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      wr_cnt_q   <= wr_cnt_d;
      fill_ptr_q <= fill_ptr_d;
      send_ptr_q <= send_ptr_d;
      full_q     <= full_d;
      row_q      <= row_d;
      feat_q     <= feat_d;
      frow_q     <= frow_d;
      fidx_q     <= fidx_d;
      dout_q     <= dout_d;
    end
  end

  // Row storage needs no reset; the full flags gate every read.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q[fill_ptr_q][wr_cnt_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_conv_row_sender.sv
// Randomized bench for conv_row_sender against a row-level
// timing/data model (rows, labels, send cycle predictions).
module tb_conv_row_sender;

  localparam int DW  = 32;
  localparam int RS  = 6;
  localparam int NR  = 6;
  localparam int NF  = 4;
  localparam int GAP = 2;
  localparam int RW  = DW * RS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          valid;
  logic [1:0]    feature_idx;
  logic [2:0]    feature_row;
  logic [RW-1:0] data_out;
  logic          frame_done;

  conv_row_sender #(
    .DATA_WIDTH(DW),
    .ROW_SIZE(RS),
    .NUM_ROWS(NR),
    .NUM_FEATURES(NF),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .valid(valid),
    .feature_idx(feature_idx),
    .feature_row(feature_row),
    .data_out(data_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [RW-1:0] got,
                     input logic [RW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int            t;
    logic [RW-1:0] d;
    logic [1:0]    fi;
    logic [2:0]    fr;
    logic          fd;
  } row_t;

  row_t          q[$];
  logic [RW-1:0] cur;
  int            cnt, pend, seq, last_t, last_v;
  int            n_pulse = 0, n_fd = 0, fd_at = 0;
  int            last_acc = 0;
  logic          exp_v;
  row_t          r;

  task automatic model_reset();
    q.delete();
    cnt    = 0;
    pend   = 0;
    seq    = 0;
    last_t = -1000;
    last_v = -1000;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ctl", {valid, frame_done, in_ready,
                      feature_idx, feature_row}, '0);
      chk("rst_data", data_out, '0);
      model_reset();
    end else begin
      exp_v = !clear && q.size() > 0 && q[0].t == cyc;
      chk("ready", in_ready, pend < 2);
      chk("valid", valid, exp_v);
      if (exp_v && valid) begin
        chk("data", data_out, q[0].d);
        chk("fidx", feature_idx, q[0].fi);
        chk("frow", feature_row, q[0].fr);
        chk("fdone", frame_done, q[0].fd);
        chk("spacing", (cyc - last_v) >= GAP + 2, 1);
        last_v = cyc;
        n_pulse++;
        if (frame_done) begin
          n_fd++;
          fd_at = n_pulse;
        end
        void'(q.pop_front());
        pend--;
      end else begin
        chk("fdone_idle", frame_done, 0);
      end
      if (clear) begin
        model_reset();
      end else if (in_valid && in_ready) begin
        cur[RW-1-cnt*DW -: DW] = in_data;
        cnt++;
        if (cnt == RS) begin
          r.t  = (cyc + 2 > last_t + GAP + 2) ? cyc + 2 : last_t + GAP + 2;
          r.d  = cur;
          r.fr = 3'(seq % NR);
          r.fi = 2'((seq / NR) % NF);
          r.fd = (seq % NR == NR - 1) && ((seq / NR) % NF == NF - 1);
          q.push_back(r);
          last_t = r.t;
          seq++;
          pend++;
          cnt = 0;
        end
      end
    end
  end

  logic [DW-1:0] tab [RS];

  task automatic drive(input int n, input int pct, input bit use_tab);
    int done = 0;
    int guard = 0;
    while (done < n && guard < 2000) begin
      in_valid = ($urandom_range(0, 99) < pct);
      in_data  = use_tab ? tab[done % RS] : $urandom;
      @(negedge clk);
      if (in_valid && in_ready) begin
        done++;
        last_acc = cyc;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (done < n) chk("drv_timeout", done, n);
  endtask

  task automatic wait_lat(input string tag);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (valid) break;
    end
    chk(tag, cyc - last_acc, 2);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int pct;
    tab[0] = 32'h3F800000;
    tab[1] = 32'h40000000;
    tab[2] = 32'h40400000;
    tab[3] = 32'h40800000;
    tab[4] = 32'h40A00000;
    tab[5] = 32'h40C00000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    drive(6, 100, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (valid) break;
    end
    chk("lat_first", cyc - last_acc, 2);
    chk("top_slot", data_out[RW-1 -: DW], 32'h3F800000);
    chk("bot_slot", data_out[DW-1:0], 32'h40C00000);
    chk("first_lbl", {feature_idx, feature_row}, 0);
    @(posedge clk);
    #1;

    pulse_rst();
    n_pulse = 0;
    n_fd    = 0;
    fd_at   = 0;
    drive(25 * RS, 100, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("stream_pulses", n_pulse, 25);
    chk("stream_fd_cnt", n_fd, 1);
    chk("stream_fd_at", fd_at, 24);

    drive(RS, 50, 1'b0);
    wait_lat("lat_toggle");

    for (int b = 0; b < 12; b++) begin
      pct = $urandom_range(30, 100);
      for (int c = 0; c < 50; c++) begin
        in_valid = ($urandom_range(0, 99) < pct);
        in_data  = $urandom;
        clear    = ($urandom_range(0, 59) == 0);
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    clear    = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    pulse_rst();
    drive(3, 100, 1'b0);
    pulse_rst();
    drive(RS, 100, 1'b0);
    wait_lat("lat_after_rst");
    chk("rst_row_lbl", {feature_idx, feature_row}, 0);

    pulse_clear();
    drive(RS, 100, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    drive(RS + 3, 100, 1'b0);
    chk("in_gap", cyc - last_v, 2);
    chk("pre_clr_row", feature_row, 1);
    pulse_clear();
    chk("clr_lbl", {feature_idx, feature_row}, 0);
    repeat (10) @(posedge clk);
    #1;
    drive(RS, 100, 1'b0);
    wait_lat("lat_after_clr");
    chk("clr_row_lbl", {feature_idx, feature_row}, 0);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
